// File: rtl/fizz_buzz_checker.sv
// -----------------------------------------------------------------------------
// fizz_buzz_checker
//   Receive-side monitor for the fizz/buzz/fizzbuzz flag stream produced by the
//   counter-based generator. It recovers the generator's modulo-MAX_CYCLES
//   count (phase) from the flags alone, locks to it, and then checks every
//   later beat against the predicted flags. Deviations are pulsed on err and
//   counted in a saturating counter. Repeated misses drop the lock.
//
// Ports
//   clk        in   1        clock, rising edge
//   resetn     in   1        synchronous, active-low reset
//   in_valid   in   1        a flag beat is present this cycle
//   fizz       in   1        received fizz flag
//   buzz       in   1        received buzz flag
//   fizzbuzz   in   1        received fizzbuzz flag
//   locked     out  1        phase recovered and being tracked
//   phase      out  PW       recovered count of the last accepted beat
//   err        out  1        1-cycle pulse: last beat mismatched while LOCKED
//   lock_lost  out  1        1-cycle pulse: LOCKED -> HUNT
//   err_count  out  ERR_W    saturating count of err pulses since reset
//   dbg_state  out  2        FSM state: 0=HUNT, 1=VERIFY, 2=LOCKED
//
// Handshake: a beat is consumed on every rising edge where in_valid=1; there
//   is no back-pressure. All outputs are registered and reflect a beat on the
//   cycle after it is consumed.
// -----------------------------------------------------------------------------
module fizz_buzz_checker #(
   parameter int FIZZ        = 3,
   parameter int BUZZ        = 5,
   parameter int MAX_CYCLES  = 100,
   parameter int LOSS_THRESH = 3,
   parameter int ERR_W       = 8
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          in_valid,
   input  logic                          fizz,
   input  logic                          buzz,
   input  logic                          fizzbuzz,
   output logic                          locked,
   output logic [$clog2(MAX_CYCLES)-1:0] phase,
   output logic                          err,
   output logic                          lock_lost,
   output logic [ERR_W-1:0]              err_count,
   output logic [1:0]                    dbg_state
);

   localparam int PW  = $clog2(MAX_CYCLES);
   localparam int VCW = $clog2(MAX_CYCLES + 1);
   localparam int MW  = $clog2(LOSS_THRESH + 1);

   localparam logic [PW-1:0]  CNT_LAST  = PW'(MAX_CYCLES - 1);
   localparam logic [VCW-1:0] VCNT_DONE = VCW'(MAX_CYCLES);
   localparam logic [MW-1:0]  MISS_LIM  = MW'(LOSS_THRESH);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      cand_q, cand_d;
   logic [VCW-1:0]     vcnt_q, vcnt_d;
   logic [MW-1:0]      miss_q, miss_d;
   logic [PW-1:0]      phase_q, phase_d;
   logic               locked_q, locked_d;
   logic               err_q, err_d;
   logic               lock_lost_q, lock_lost_d;
   logic [ERR_W-1:0]   err_count_q, err_count_d;

   // Generator count successor, wrapping at MAX_CYCLES-1.
   function automatic logic [PW-1:0] next_cnt(input logic [PW-1:0] c);
      return (c == CNT_LAST) ? '0 : c + 1'b1;
   endfunction

   // True when the received flags equal the flags expected for count c.
   // A malformed beat (fizzbuzz != fizz&buzz) can never match.
   function automatic logic beat_match(input logic [PW-1:0] c,
                                       input logic f, input logic b,
                                       input logic fb);
      logic ef, eb;
      ef = ((int'(c) % FIZZ) == 0);
      eb = ((int'(c) % BUZZ) == 0);
      return ({f, b, fb} == {ef, eb, ef & eb}) && (fb == (f & b));
   endfunction

   logic          all_set;
   logic [PW-1:0] cand_nxt;
   logic [PW-1:0] phase_nxt;

   always_comb begin
      all_set   = fizz & buzz & fizzbuzz;
      cand_nxt  = next_cnt(cand_q);
      phase_nxt = next_cnt(phase_q);

      state_d     = state_q;
      cand_d      = cand_q;
      vcnt_d      = vcnt_q;
      miss_d      = miss_q;
      phase_d     = phase_q;
      locked_d    = locked_q;
      err_d       = 1'b0;
      lock_lost_d = 1'b0;
      err_count_d = err_count_q;

      if (in_valid) begin
         unique case (state_q)
            HUNT: begin
               // Only a 1/1/1 beat pins the count to a multiple of lcm; treat
               // it as count 0 and let VERIFY prove or correct the guess.
               if (all_set) begin
                  cand_d  = '0;
                  vcnt_d  = VCW'(1);
                  state_d = VERIFY;
               end
            end

            VERIFY: begin
               cand_d = cand_nxt;
               if (beat_match(cand_nxt, fizz, buzz, fizzbuzz)) begin
                  vcnt_d = vcnt_q + 1'b1;
                  if (vcnt_q + 1'b1 == VCNT_DONE) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                     phase_d  = cand_nxt;
                     miss_d   = '0;
                  end
               end else if (all_set) begin
                  // On a clean stream a wrong seed first fails at the true
                  // count 0, which is itself a 1/1/1 beat: reseed right here.
                  cand_d = '0;
                  vcnt_d = VCW'(1);
               end else begin
                  state_d = HUNT;
               end
            end

            LOCKED: begin
               // Flywheel: the phase advances on every beat, matched or not.
               phase_d = phase_nxt;
               if (beat_match(phase_nxt, fizz, buzz, fizzbuzz)) begin
                  miss_d = '0;
               end else begin
                  err_d  = 1'b1;
                  miss_d = miss_q + 1'b1;
                  if (err_count_q != '1) begin
                     err_count_d = err_count_q + 1'b1;
                  end
                  if (miss_q + 1'b1 == MISS_LIM) begin
                     state_d     = HUNT;
                     locked_d    = 1'b0;
                     lock_lost_d = 1'b1;
                  end
               end
            end

            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= HUNT;
         cand_q      <= '0;
         vcnt_q      <= '0;
         miss_q      <= '0;
         phase_q     <= '0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         lock_lost_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         vcnt_q      <= vcnt_d;
         miss_q      <= miss_d;
         phase_q     <= phase_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
         lock_lost_q <= lock_lost_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = locked_q;
   assign phase     = phase_q;
   assign err       = err_q;
   assign lock_lost = lock_lost_q;
   assign err_count = err_count_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fizz_buzz_checker.sv
// -----------------------------------------------------------------------------
// tb_fizz_buzz_checker
//   Directed and randomized stimulus for fizz_buzz_checker. Two instances share
//   the same inputs: the default one, and one with a 2-bit error counter so
//   saturation is reachable quickly. A behavioural model written with plain
//   integer arithmetic predicts every output after every cycle.
// -----------------------------------------------------------------------------
module tb_fizz_buzz_checker;

   localparam int FIZZ = 3;
   localparam int BUZZ = 5;
   localparam int MAXC = 100;
   localparam int LT   = 3;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn, in_valid, fizz, buzz, fizzbuzz;

   logic       locked, err, lock_lost;
   logic [6:0] phase;
   logic [7:0] err_count;
   logic [1:0] dbg_state;

   logic       locked2, err2, lock_lost2;
   logic [6:0] phase2;
   logic [1:0] err_count2;
   logic [1:0] dbg_state2;

   fizz_buzz_checker u_dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid),
      .fizz(fizz), .buzz(buzz), .fizzbuzz(fizzbuzz),
      .locked(locked), .phase(phase), .err(err), .lock_lost(lock_lost),
      .err_count(err_count), .dbg_state(dbg_state)
   );

   fizz_buzz_checker #(.ERR_W(2)) u_dut_w2 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid),
      .fizz(fizz), .buzz(buzz), .fizzbuzz(fizzbuzz),
      .locked(locked2), .phase(phase2), .err(err2), .lock_lost(lock_lost2),
      .err_count(err_count2), .dbg_state(dbg_state2)
   );

   int total = 0;
   int bad   = 0;

   // reference model: 0=hunt, 1=verify, 2=locked
   int m_state, m_cand, m_vcnt, m_miss, m_phase;
   int m_locked, m_err, m_lost, m_errc8, m_errc2;

   int gen_cnt;   // true generator count of the next beat sent

   task automatic model_reset();
      m_state = 0; m_cand = 0; m_vcnt = 0; m_miss = 0; m_phase = 0;
      m_locked = 0; m_err = 0; m_lost = 0; m_errc8 = 0; m_errc2 = 0;
   endtask

   function automatic bit good_for(int c, bit f, bit b, bit fb);
      bit ef, eb;
      ef = (c % FIZZ == 0);
      eb = (c % BUZZ == 0);
      return (f == ef) && (b == eb) && (fb == (ef && eb)) && (fb == (f && b));
   endfunction

   task automatic model_beat(bit v, bit f, bit b, bit fb);
      int nc;
      m_err  = 0;
      m_lost = 0;
      if (v) begin
         if (m_state == 0) begin
            if (f && b && fb) begin
               m_cand = 0; m_vcnt = 1; m_state = 1;
            end
         end else if (m_state == 1) begin
            nc = (m_cand + 1) % MAXC;
            m_cand = nc;
            if (good_for(nc, f, b, fb)) begin
               m_vcnt++;
               if (m_vcnt == MAXC) begin
                  m_state = 2; m_locked = 1; m_phase = nc; m_miss = 0;
               end
            end else if (f && b && fb) begin
               m_cand = 0; m_vcnt = 1;
            end else begin
               m_state = 0;
            end
         end else begin
            m_phase = (m_phase + 1) % MAXC;
            if (good_for(m_phase, f, b, fb)) begin
               m_miss = 0;
            end else begin
               m_err = 1;
               m_miss++;
               if (m_errc8 < 255) m_errc8++;
               if (m_errc2 < 3)   m_errc2++;
               if (m_miss == LT) begin
                  m_state = 0; m_locked = 0; m_lost = 1;
               end
            end
         end
      end
   endtask

   // scoreboard comparison
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      chk("locked",       32'(locked),     32'(m_locked));
      chk("phase",        32'(phase),      32'(m_phase));
      chk("err",          32'(err),        32'(m_err));
      chk("lock_lost",    32'(lock_lost),  32'(m_lost));
      chk("err_count",    32'(err_count),  32'(m_errc8));
      chk("state",        32'(dbg_state),  32'(m_state));
      chk("w2_locked",    32'(locked2),    32'(m_locked));
      chk("w2_phase",     32'(phase2),     32'(m_phase));
      chk("w2_err",       32'(err2),       32'(m_err));
      chk("w2_lock_lost", 32'(lock_lost2), 32'(m_lost));
      chk("w2_err_count", 32'(err_count2), 32'(m_errc2));
      chk("w2_state",     32'(dbg_state2), 32'(m_state));
   endtask

   // driver tasks: inputs change on the falling edge, outputs are checked on
   // the following falling edge, i.e. one rising edge after the beat
   task automatic step(input bit v, input bit f, input bit b, input bit fb);
      in_valid = v; fizz = f; buzz = b; fizzbuzz = fb;
      model_beat(v, f, b, fb);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      in_valid = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check_all();
      resetn = 1'b1;
   endtask

   // golden beat for the current generator count; corrupt flips fizz
   task automatic gold(input bit corrupt);
      bit f, b;
      f = (gen_cnt % FIZZ == 0);
      b = (gen_cnt % BUZZ == 0);
      step(1'b1, f ^ corrupt, b, f & b);
      gen_cnt = (gen_cnt + 1) % MAXC;
   endtask

   task automatic gap();
      step(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           1'($urandom_range(1, 0)));
   endtask

   // send golden beats from count 0 until lock; returns beats used (-1 if none)
   task automatic lock_from_zero(output int beats);
      beats = -1;
      gen_cnt = 0;
      for (int i = 1; i <= 150; i++) begin
         gold(1'b0);
         if (locked === 1'b1) begin
            beats = i;
            break;
         end
      end
   endtask

   initial begin
      int n;
      int vb;
      resetn = 1'b0; in_valid = 1'b0; fizz = 1'b0; buzz = 1'b0; fizzbuzz = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();
      do_reset();

      // golden stream from count 0: lock on beat 100 at count 99
      lock_from_zero(n);
      chk("t1_lock_beat", 32'(n), 32'd100);
      chk("t1_lock_phase", 32'(phase), 32'd99);
      for (int i = 0; i < 20; i++) gold(1'b0);

      // flip buzz at count 20: single err pulse, lock kept, flywheel continues
      in_valid = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b0);   // count 20 should be 0/1/0
      gen_cnt = 21;
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_err_count", 32'(err_count), 32'd1);
      chk("t3_locked", 32'(locked), 32'd1);
      gold(1'b0);
      chk("t3_phase_21", 32'(phase), 32'd21);
      chk("t3_err_clear", 32'(err), 32'd0);

      // fresh lock, then corrupt counts 40, 41, 42
      do_reset();
      lock_from_zero(n);
      chk("t4_relock", 32'(n), 32'd100);
      while (gen_cnt != 40) gold(1'b0);
      gold(1'b1);
      gold(1'b1);
      chk("t4_still_locked", 32'(locked), 32'd1);
      gold(1'b1);
      chk("t4_err3", 32'(err), 32'd1);
      chk("t4_lock_lost", 32'(lock_lost), 32'd1);
      chk("t4_locked_low", 32'(locked), 32'd0);
      chk("t4_err_count", 32'(err_count), 32'd3);
      chk("t4_hunt", 32'(dbg_state), 32'd0);
      gold(1'b0);
      chk("t4_lost_pulse_1cyc", 32'(lock_lost), 32'd0);

      // stream starting at count 15: wrong seed, reseed at beat 86, lock at 185
      do_reset();
      gen_cnt = 15;
      n = -1;
      for (int i = 1; i <= 300; i++) begin
         gold(1'b0);
         if (locked === 1'b1) begin
            n = i;
            break;
         end
      end
      chk("t2_lock_beat", 32'(n), 32'd185);
      chk("t2_phase", 32'(phase), 32'd99);

      // malformed 0/0/1 in HUNT never seeds
      do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("t5_no_seed", 32'(dbg_state), 32'd0);

      // random gaps on golden stream: lock after 100 accepted beats
      gen_cnt = 0;
      vb = 0;
      n = -1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(1, 0) == 1) begin
            gold(1'b0);
            vb++;
         end else begin
            gap();
         end
         if (locked === 1'b1) begin
            n = vb;
            break;
         end
      end
      chk("t5_lock_beats", 32'(n), 32'd100);
      chk("t5_no_err", 32'(err_count), 32'd0);

      // five isolated errors: 8-bit counter reads 5, 2-bit counter saturates
      for (int k = 0; k < 5; k++) begin
         gold(1'b1);
         for (int j = 0; j < 3; j++) gold(1'b0);
      end
      chk("t6_err_count8", 32'(err_count), 32'd5);
      chk("t6_err_count2", 32'(err_count2), 32'd3);
      chk("t6_locked", 32'(locked), 32'd1);

      // reset in the middle of VERIFY
      do_reset();
      gen_cnt = 0;
      for (int i = 0; i < 10; i++) gold(1'b0);
      chk("t6_in_verify", 32'(dbg_state), 32'd1);
      do_reset();
      chk("t6_rst_state", 32'(dbg_state), 32'd0);
      chk("t6_rst_errc", 32'(err_count), 32'd0);

      // randomized: random start, random gaps, then sparse corruption
      gen_cnt = $urandom_range(MAXC - 1, 0);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(9, 0) < 7) gold(1'b0);
         else gap();
      end
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(9, 0) < 7) gold($urandom_range(19, 0) == 0);
         else gap();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global time limit
   initial begin
      #200000;
      bad++;
      $display("FAIL timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
